// File: rtl/mac_pkg.sv
// Purpose: shared types and sizing helpers for the MAC TX arbiter slice.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PKT   = 2'd1,
        FLUSH = 2'd2,
        IFG   = 2'd3
    } arb_state_e;

    // Width of the valid-byte count: enough to hold 0..DATA_W/8.
    function automatic int len_w(input int data_w);
        return $clog2(data_w / 8) + 1;
    endfunction

    // Inter-frame gap in clock cycles, rounded up to whole beats.
    function automatic int ifg_cycles(input int ifg_bytes, input int data_w);
        int bpb;
        bpb = data_w / 8;
        return (ifg_bytes + bpb - 1) / bpb;
    endfunction

endpackage

// File: rtl/pkt_arb_pick.sv
// Purpose: one-hot winner picker; round-robin from ptr_i with MAC_TX_ARB_RR_EN, else lowest index wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module pkt_arb_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
`ifdef MAC_TX_ARB_RR_EN
    input  logic [PTR_W-1:0] ptr_i,
`endif
    output logic [N_REQ-1:0] grant_o
);

`ifdef MAC_TX_ARB_RR_EN
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] first;
    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Rotate so ptr_i sits at bit 0, take the first set bit, rotate back.
    always_comb begin
        rot     = '0;
        first   = '0;
        grant_o = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, PTR_W'(i)} + {1'b0, ptr_i};
            if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
            idx = sum[PTR_W-1:0];
            rot[i] = req_i[idx];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (rot[i] && !found) begin
                first[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, PTR_W'(i)} + {1'b0, ptr_i};
            if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
            idx = sum[PTR_W-1:0];
            grant_o[idx] = first[i];
        end
    end
`else
    logic found;

    // Fixed priority: lowest requesting index wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_i[i] && !found) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mac_tx_arb.sv
// Purpose: frame-granular arbiter of N_REQ sources onto one MAC TX stream (MAC_TX_ARB_RR_EN selects round-robin).
// Latency: accepted beat appears on the registered outputs 1 cycle later; ready is combinational.
// Backpressure: ready only to the frame owner; all ready low during the inter-frame gap.
module mac_tx_arb
    import mac_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int LEN_W     = len_w(DATA_W),
    parameter int N_REQ     = 2,
    parameter int IFG_BYTES = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_start_i,
    input  logic [N_REQ-1:0]        req_term_i,
    input  logic [N_REQ-1:0]        req_cancel_i,
    input  logic [N_REQ*LEN_W-1:0]  req_len_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    valid_o,
    output logic                    start_o,
    output logic                    term_o,
    output logic                    idle_o,
    output logic                    cancel_o,
    output logic [LEN_W-1:0]        len_o,
    output logic [DATA_W-1:0]       data_o
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int IFG_CYC = ifg_cycles(IFG_BYTES, DATA_W);
    localparam int CNT_W   = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]  gidx_q, gidx_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic              term_q, term_d;
    logic              idle_q, idle_d;
    logic              cancel_q, cancel_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [N_REQ-1:0]  pick;
    logic [PTR_W-1:0]  pick_idx;
    logic [PTR_W-1:0]  sel;
    logic [LEN_W-1:0]  sel_len;
    logic [DATA_W-1:0] sel_data;

`ifdef MAC_TX_ARB_RR_EN
    logic [PTR_W-1:0]  ptr_q, ptr_d;
`endif

    function automatic logic [PTR_W-1:0] oh2idx(input logic [N_REQ-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) oh2idx = PTR_W'(i);
        end
    endfunction

    pkt_arb_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i   (req_valid_i & req_start_i),
`ifdef MAC_TX_ARB_RR_EN
        .ptr_i   (ptr_q),
`endif
        .grant_o (pick)
    );

    // Steer the payload of whichever requester is being served this cycle.
    always_comb begin
        pick_idx = oh2idx(pick);
        sel      = (state_q == IDLE) ? pick_idx : gidx_q;
        sel_len  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == PTR_W'(i)) begin
                sel_len  = req_len_i[i*LEN_W +: LEN_W];
                sel_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Frame FSM: next state, ready, and the next value of every output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        req_ready_o = '0;
        valid_d     = 1'b1;
        start_d     = 1'b0;
        term_d      = 1'b0;
        idle_d      = 1'b0;
        cancel_d    = 1'b0;
        len_d       = '0;
        data_d      = '0;
`ifdef MAC_TX_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Stray mid-frame beats are drained so a source cannot wedge itself.
                req_ready_o = pick | (req_valid_i & ~req_start_i);
                idle_d      = 1'b1;
                if (|pick) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
`ifdef MAC_TX_ARB_RR_EN
                    ptr_d   = (pick_idx == PTR_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
`endif
                    idle_d  = 1'b0;
                    start_d = 1'b1;
                    data_d  = sel_data;
                    if (req_term_i[sel]) begin
                        term_d  = 1'b1;
                        len_d   = sel_len;
                        state_d = IFG;
                        cnt_d   = CNT_W'(IFG_CYC - 1);
                    end else begin
                        state_d = PKT;
                    end
                end
            end
            PKT: begin
                req_ready_o = grant_q;
                if (req_cancel_i[sel]) begin
                    // Cancel takes precedence over a term on the same beat.
                    cancel_d = 1'b1;
                    state_d  = IFG;
                    cnt_d    = CNT_W'(IFG_CYC - 1);
                end else if (req_valid_i[sel]) begin
                    data_d = sel_data;
                    if (req_term_i[sel]) begin
                        term_d  = 1'b1;
                        len_d   = sel_len;
                        state_d = IFG;
                        cnt_d   = CNT_W'(IFG_CYC - 1);
                    end
                end else begin
                    // Underrun: mac_tx cannot stall, so abort and drain the rest.
                    cancel_d = 1'b1;
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                req_ready_o = grant_q;
                idle_d      = 1'b1;
                if (req_valid_i[sel] && req_term_i[sel]) begin
                    state_d = IFG;
                    cnt_d   = CNT_W'(IFG_CYC - 1);
                end
            end
            IFG: begin
                idle_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any frame in flight silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= '0;
            gidx_q   <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            term_q   <= 1'b0;
            idle_q   <= 1'b0;
            cancel_q <= 1'b0;
            len_q    <= '0;
            data_q   <= '0;
`ifdef MAC_TX_ARB_RR_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            term_q   <= term_d;
            idle_q   <= idle_d;
            cancel_q <= cancel_d;
            len_q    <= len_d;
            data_q   <= data_d;
`ifdef MAC_TX_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign grant_o  = grant_q;
    assign valid_o  = valid_q;
    assign start_o  = start_q;
    assign term_o   = term_q;
    assign idle_o   = idle_q;
    assign cancel_o = cancel_q;
    assign len_o    = len_q;
    assign data_o   = data_q;

endmodule
